// File: rtl/jt10_adpcm_gain_ramp.sv
// Per-channel ADPCM attenuator for time-multiplexed slots.
// Holds pan/level per channel, optionally slews gain, applies dB->linear gain.
module jt10_adpcm_gain_ramp #(
    parameter int CHANNELS = 6,
    parameter int DW       = 16,
    parameter int RAMP     = 1,
    localparam int CHW     = $clog2(CHANNELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic                 wr_en,
    input  logic [CHW-1:0]       wr_ch,
    input  logic [7:0]           wr_data,
    input  logic [5:0]           atl,
    input  logic                 in_valid,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [DW-1:0] pcm_in,
    output logic                 out_valid,
    output logic [CHW-1:0]       out_ch,
    output logic [1:0]           lr,
    output logic signed [DW-1:0] pcm_att
);

    localparam logic [6:0] DB_RST = (RAMP != 0) ? 7'd127 : 7'd0;

    // {lr[1:0], level[4:0]} per channel; wr_data[5] is not stored
    logic [6:0] lracl  [CHANNELS];
    logic [6:0] cur_db [CHANNELS];

    logic       in_range;
    logic       wr_ok;
    logic [6:0] rd_reg;
    logic [6:0] rd_db;
    logic [6:0] target_db;
    logic [6:0] next_db;
    logic [9:0] lin;
    logic       unused_bit;

    logic                 s1_valid;
    logic [CHW-1:0]       s1_ch;
    logic [1:0]           s1_lr;
    logic signed [DW-1:0] s1_pcm;
    logic [9:0]           s1_lin;
    logic [2:0]           s1_sh;
    logic                 s1_mute;

    logic                 s2_valid;
    logic [CHW-1:0]       s2_ch;
    logic [1:0]           s2_lr;
    logic signed [DW-1:0] s2_val;
    logic [2:0]           s2_sh;
    logic                 s2_mute;

    logic signed [DW+10:0] prod;

    assign unused_bit = wr_data[5];
    assign in_range   = int'(in_ch) < CHANNELS;
    assign wr_ok      = wr_en && (int'(wr_ch) < CHANNELS);

    always_comb begin
        rd_reg = 7'd0;
        rd_db  = DB_RST;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_ch == CHW'(i)) begin
                rd_reg = lracl[i];
                rd_db  = cur_db[i];
            end
        end
        // same-cycle write to the sampled channel takes effect immediately
        if (wr_ok && wr_ch == in_ch)
            rd_reg = {wr_data[7:6], wr_data[4:0]};
    end

    assign target_db = {2'b00, ~rd_reg[4:0]} + {1'b0, ~atl};

    always_comb begin
        next_db = target_db;
        if (RAMP != 0) begin
            if (rd_db < target_db)
                next_db = rd_db + 7'd1;
            else if (rd_db > target_db)
                next_db = rd_db - 7'd1;
            else
                next_db = rd_db;
        end
    end

    always_comb begin
        case (next_db[2:0])
            3'd0:    lin = 10'd512;
            3'd1:    lin = 10'd470;
            3'd2:    lin = 10'd431;
            3'd3:    lin = 10'd395;
            3'd4:    lin = 10'd362;
            3'd5:    lin = 10'd332;
            3'd6:    lin = 10'd305;
            default: lin = 10'd280;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                lracl[i]  <= 7'd0;
                cur_db[i] <= DB_RST;
            end
        end else if (cen) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_ok && wr_ch == CHW'(i))
                    lracl[i] <= {wr_data[7:6], wr_data[4:0]};
                if (in_valid && in_range && in_ch == CHW'(i))
                    cur_db[i] <= next_db;
            end
        end
    end

    assign prod = $signed(s1_pcm) * $signed({1'b0, s1_lin});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_lr     <= 2'd0;
            s1_pcm    <= '0;
            s1_lin    <= 10'd0;
            s1_sh     <= 3'd0;
            s1_mute   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_ch     <= '0;
            s2_lr     <= 2'd0;
            s2_val    <= '0;
            s2_sh     <= 3'd0;
            s2_mute   <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            lr        <= 2'd0;
            pcm_att   <= '0;
        end else if (cen) begin
            s1_valid  <= in_valid;
            s1_ch     <= in_ch;
            s1_lr     <= in_range ? rd_reg[6:5] : 2'd0;
            s1_pcm    <= pcm_in;
            s1_lin    <= lin;
            s1_sh     <= next_db[5:3];
            s1_mute   <= !in_range || next_db[6];
            s2_valid  <= s1_valid;
            s2_ch     <= s1_ch;
            s2_lr     <= s1_lr;
            s2_val    <= DW'(prod >>> 9);
            s2_sh     <= s1_sh;
            s2_mute   <= s1_mute;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_ch  <= s2_ch;
                lr      <= s2_lr;
                pcm_att <= s2_mute ? '0 : (s2_val >>> s2_sh);
            end
        end
    end

endmodule

// File: tb/tb_jt10_adpcm_gain_ramp.sv
// Directed bench for jt10_adpcm_gain_ramp.
// One RAMP=0 and one RAMP=1 instance share the same stimulus.
module tb_jt10_adpcm_gain_ramp;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cen = 1'b1;
    logic              wr_en = 1'b0;
    logic [2:0]        wr_ch = 3'd0;
    logic [7:0]        wr_data = 8'd0;
    logic [5:0]        atl = 6'd63;
    logic              in_valid = 1'b0;
    logic [2:0]        in_ch = 3'd0;
    logic signed [15:0] pcm_in = 16'sd0;

    logic              a_valid, r_valid;
    logic [2:0]        a_ch, r_ch;
    logic [1:0]        a_lr, r_lr;
    logic signed [15:0] a_pcm, r_pcm;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    jt10_adpcm_gain_ramp #(.CHANNELS(6), .DW(16), .RAMP(0)) dut_a (
        .clk(clk), .rst(rst), .cen(cen),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .atl(atl),
        .in_valid(in_valid), .in_ch(in_ch), .pcm_in(pcm_in),
        .out_valid(a_valid), .out_ch(a_ch), .lr(a_lr), .pcm_att(a_pcm)
    );

    jt10_adpcm_gain_ramp #(.CHANNELS(6), .DW(16), .RAMP(1)) dut_r (
        .clk(clk), .rst(rst), .cen(cen),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .atl(atl),
        .in_valid(in_valid), .in_ch(in_ch), .pcm_in(pcm_in),
        .out_valid(r_valid), .out_ch(r_ch), .lr(r_lr), .pcm_att(r_pcm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] ch, input logic [7:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic send_one(input logic [2:0] ch, input logic signed [15:0] p);
        in_valid = 1'b1; in_ch = ch; pcm_in = p;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (a_valid !== 1'b0) $display("FAIL rst_a_valid got %b want 0", a_valid); else passed++;
        total++; if (a_ch !== 3'd0) $display("FAIL rst_a_ch got %0d want 0", a_ch); else passed++;
        total++; if (a_lr !== 2'd0) $display("FAIL rst_a_lr got %0d want 0", a_lr); else passed++;
        total++; if (a_pcm !== 16'sd0) $display("FAIL rst_a_pcm got %0d want 0", a_pcm); else passed++;
        total++; if (r_valid !== 1'b0) $display("FAIL rst_r_valid got %b want 0", r_valid); else passed++;
        total++; if (r_pcm !== 16'sd0) $display("FAIL rst_r_pcm got %0d want 0", r_pcm); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        int k;
        int exp_v;
        atl = 6'd63;
        write_reg(3'd2, 8'hDF);
        for (int i = 0; i < 130; i++) begin
            if (i < 128) begin
                in_valid = 1'b1; in_ch = 3'd2; pcm_in = 16'sd1000;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 2) begin
                k = i - 1;
                exp_v = -1;
                if (k == 1 || k == 63) exp_v = 0;
                if (k == 64 || k == 65) exp_v = 4;
                if (k == 127 || k == 128) exp_v = 1000;
                if (exp_v >= 0) begin
                    total++;
                    if (r_valid !== 1'b1 || r_pcm !== 16'(exp_v))
                        $display("FAIL ramp_sample%0d got v=%b pcm=%0d want pcm=%0d", k, r_valid, r_pcm, exp_v);
                    else passed++;
                end
            end
        end
        in_valid = 1'b0;
        write_reg(3'd3, 8'hDF);
        send_one(3'd3, 16'sd1000);
        total++;
        if (r_valid !== 1'b1 || r_pcm !== 16'sd0)
            $display("FAIL ramp_ch3_untouched got v=%b pcm=%0d want pcm=0", r_valid, r_pcm);
        else passed++;
    endtask

    task automatic test_basic();
        atl = 6'd63;
        write_reg(3'd0, 8'hDF);
        send_one(3'd0, 16'sd1000);
        total++; if (a_valid !== 1'b1 || a_pcm !== 16'sd1000) $display("FAIL db0 got v=%b pcm=%0d want 1000", a_valid, a_pcm); else passed++;
        total++; if (a_lr !== 2'd3) $display("FAIL db0_lr got %0d want 3", a_lr); else passed++;
        write_reg(3'd0, 8'h9E);
        send_one(3'd0, 16'sd1000);
        total++; if (a_pcm !== 16'sd917) $display("FAIL db1_pos got %0d want 917", a_pcm); else passed++;
        total++; if (a_lr !== 2'd2) $display("FAIL db1_lr got %0d want 2", a_lr); else passed++;
        send_one(3'd0, -16'sd1000);
        total++; if (a_pcm !== -16'sd918) $display("FAIL db1_neg got %0d want -918", a_pcm); else passed++;
        write_reg(3'd0, 8'h56);
        send_one(3'd0, 16'sd1000);
        total++; if (a_pcm !== 16'sd458) $display("FAIL db9 got %0d want 458", a_pcm); else passed++;
    endtask

    task automatic test_mute();
        write_reg(3'd0, 8'hC0);
        atl = 6'd0;
        send_one(3'd0, 16'sd1000);
        total++; if (a_valid !== 1'b1 || a_pcm !== 16'sd0) $display("FAIL db94_mute got v=%b pcm=%0d want 0", a_valid, a_pcm); else passed++;
        atl = 6'd62;
        send_one(3'd0, 16'sd1600);
        total++; if (a_pcm !== 16'sd100) $display("FAIL db32 got %0d want 100", a_pcm); else passed++;
        atl = 6'd63;
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] exp_p [6];
        logic [1:0]         exp_l [6];
        int j;
        exp_p = '{16'sd1000, 16'sd917, 16'sd841, 16'sd771, 16'sd458, 16'sd648};
        exp_l = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd1, 2'd2};
        write_reg(3'd0, 8'hDF);
        write_reg(3'd1, 8'hBE);
        write_reg(3'd2, 8'h5D);
        write_reg(3'd3, 8'hDC);
        write_reg(3'd4, 8'hDB);
        write_reg(3'd5, 8'h9A);
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                in_valid = 1'b1; in_ch = 3'(i); pcm_in = 16'sd1000;
                wr_en = (i == 4); wr_ch = 3'd4; wr_data = 8'h56;
            end else begin
                in_valid = 1'b0; wr_en = 1'b0;
            end
            tick();
            if (i >= 2) begin
                j = i - 2;
                total++;
                if (a_valid !== 1'b1 || a_ch !== 3'(j) || a_pcm !== exp_p[j] || a_lr !== exp_l[j])
                    $display("FAIL b2b_slot%0d got v=%b ch=%0d pcm=%0d lr=%0d want ch=%0d pcm=%0d lr=%0d",
                             j, a_valid, a_ch, a_pcm, a_lr, j, exp_p[j], exp_l[j]);
                else passed++;
            end
        end
        wr_en = 1'b0;
        send_one(3'd7, 16'sd1000);
        total++;
        if (a_valid !== 1'b1 || a_ch !== 3'd7 || a_pcm !== 16'sd0 || a_lr !== 2'd0)
            $display("FAIL oob_ch got v=%b ch=%0d pcm=%0d lr=%0d want ch=7 pcm=0 lr=0", a_valid, a_ch, a_pcm, a_lr);
        else passed++;
    endtask

    task automatic test_cen();
        cen = 1'b0;
        in_valid = 1'b1; in_ch = 3'd0; pcm_in = 16'sd1000;
        tick();
        tick();
        total++; if (a_valid !== 1'b1 || a_ch !== 3'd7) $display("FAIL cen_hold got v=%b ch=%0d want v=1 ch=7", a_valid, a_ch); else passed++;
        in_valid = 1'b0;
        cen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (a_valid !== 1'b0) $display("FAIL cen_ignored_%0d got v=%b want 0", i, a_valid); else passed++;
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_ch = 3'd0; pcm_in = 16'(100 * (i + 1));
            tick();
        end
        in_valid = 1'b0;
        total++; if (a_valid !== 1'b1 || a_pcm !== 16'sd100) $display("FAIL inflight_first got v=%b pcm=%0d want 100", a_valid, a_pcm); else passed++;
        rst = 1'b1;
        #1;
        total++; if (a_valid !== 1'b0 || r_valid !== 1'b0) $display("FAIL rst_async got a=%b r=%b want 0", a_valid, r_valid); else passed++;
        total++; if (a_pcm !== 16'sd0) $display("FAIL rst_async_pcm got %0d want 0", a_pcm); else passed++;
        tick();
        rst = 1'b0;
        write_reg(3'd0, 8'hDF);
        in_valid = 1'b1; in_ch = 3'd0; pcm_in = 16'sd1234;
        tick();
        in_valid = 1'b0;
        total++; if (a_valid !== 1'b0) $display("FAIL post_rst_c1 got v=%b want 0", a_valid); else passed++;
        tick();
        total++; if (a_valid !== 1'b0) $display("FAIL post_rst_c2 got v=%b want 0", a_valid); else passed++;
        tick();
        total++; if (a_valid !== 1'b1 || a_pcm !== 16'sd1234) $display("FAIL post_rst_c3 got v=%b pcm=%0d want 1234", a_valid, a_pcm); else passed++;
        tick();
        total++; if (a_valid !== 1'b0) $display("FAIL post_rst_c4 got v=%b want 0", a_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_basic();
        test_mute();
        test_back_to_back();
        test_cen();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/jt10_adpcm_gain_ramp.md
Name: jt10_adpcm_gain_ramp

Overview:
Parametrised per-channel ADPCM attenuator for time-multiplexed channel slots. It holds a pan/level register for every channel and combines it with a global total level. The result is converted from dB to a linear mantissa plus shift and applied to the incoming sample. Successor to the fixed 6-channel ring gain stage: it adds a channel-indexed valid handshake, a generic channel count and width, and optional click-free gain ramping. It sits between the ADPCM decoder output and the channel mixer.

Parameters:
CHANNELS, 6, number of time-multiplexed channels (2..16)
DW, 16, signed sample width
RAMP, 1, 1 = current attenuation slews one step per channel sample; 0 = immediate
CHW, derived $clog2(CHANNELS), channel index width (localparam)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
cen  in  1  clock enable; all state advances only when cen=1
wr_en  in  1  write the lracl register of wr_ch
wr_ch  in  CHW  channel index for write
wr_data  in  8  [7:6] L/R enable, [4:0] level (31 = loudest); bit 5 ignored
atl  in  6  ADPCM total level (63 = loudest), sampled every cycle
in_valid  in  1  sample present
in_ch  in  CHW  channel of sample
pcm_in  in  DW  signed sample
out_valid  out  1  attenuated sample present
out_ch  out  CHW  channel of output
lr  out  2  L/R enables of out_ch
pcm_att  out  DW  signed attenuated sample

Behaviour:
- Reset:
  - outputs: out_valid=0, out_ch=0, lr=0, pcm_att=0.
  - all lracl registers = 0.
  - all cur_db = 127 when RAMP=1, 0 when RAMP=0.
  - the pipeline valid bits are cleared.
  - Reset asserted mid-operation discards in-flight samples; out_valid goes low immediately.
- Attenuation:
  - target_db[6:0] = {2'b0, ~level} + {1'b0, ~atl}, with the lracl register read for in_ch.
  - lin from db[2:0]: 512, 470, 431, 395, 362, 332, 305, 280.
  - shift sh = db[6:3]; sh >= 8 mutes the sample (output 0).
- Ramp (RAMP=1):
  - On each accepted sample of channel c, cur_db[c] moves one step toward target_db (+1 or -1, hold if equal) before it is used.
  - RAMP=0: cur_db[c] = target_db, used the same cycle.
- Pipeline (each stage advances on cen), latency 3 cen cycles from in_valid to out_valid; one sample accepted per cen, no backpressure:
  - S1: register read, ramp update, lin/sh lookup.
  - S2: prod = pcm_in * lin, signed DW+10 bits; keep prod >>> 9.
  - S3: arithmetic shift right by sh (0..7), or mute; register pcm_att, lr, out_ch; out_valid=1.
- Output fields: lr is the L/R value read in S1 for that sample. pcm_att and out_ch hold their values while out_valid=0.
- Rounding: truncation toward minus infinity (arithmetic shift), bit-exact with the previous 6-channel block. No saturation is needed because lin ≤ 512.
- wr_en and in_valid on the same channel in the same cycle: the write is bypassed, so the sample uses the new level and lr.
- atl changes apply from the next accepted sample; with RAMP=1 they slew.
- Out-of-range indices (wr_ch or in_ch ≥ CHANNELS):
  - the write is ignored;
  - the sample still produces out_valid with pcm_att=0, lr=0, and no ramp state is touched.
- cen=0: all registers hold; in_valid is ignored.

Test Plan:
- RAMP=0, level=31, atl=63 (db 0), pcm_in=1000 -> pcm_att=1000 after 3 cen cycles, lr equals written bits.
- RAMP=0, level=30, atl=63 (db 1): pcm 1000 -> 917, pcm -1000 -> -918. Level=22 (db 9): pcm 1000 -> 458.
- RAMP=0, level=0, atl=0 (db 94) -> pcm_att=0. Level=0, atl=62 (db 32, sh 4, lin 512): pcm 1600 -> 100.
- RAMP=1 after reset, level=31, atl=63, pcm=1000 repeated on ch 2:
  - samples 1..63 -> 0;
  - sample 64 (db 63) -> 4;
  - sample 127 onward -> 1000;
  - ch 3 cur_db stays at 127.
- CHANNELS=6 interleaved ch0..5, each with a different level; back-to-back valid every cen:
  - verify out_ch order and per-channel values;
  - verify the same-cycle write/sample bypass on ch4;
  - in_ch=7 (CHW=3) -> pcm_att=0, lr=0.
- Assert rst while 3 samples are in flight -> out_valid=0 immediately. After release, the first output appears 3 cen cycles after the first new in_valid.
